// File: rtl/mem_bus_pkg.sv
// Shared types for the I/D cache memory bus arbiter.
// Line width helper keeps port widths consistent across files.
package mem_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  function automatic int line_width(
    input int dw,
    input int ol
  );
    return dw * (1 << ol);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Two-way round-robin pick between the I and D requesters.
// On a tie the requester that did not win last time is chosen.
module rr_arbiter2
  import mem_bus_pkg::*;
(
  input  logic    req_i,
  input  logic    req_d,
  input  req_id_t last_grant,
  output logic    gnt_valid,
  output req_id_t gnt
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = REQ_I;
    unique case (1'b1)
      (req_i & ~req_d): begin
        gnt_valid = 1'b1;
        gnt       = REQ_I;
      end
      (~req_i & req_d): begin
        gnt_valid = 1'b1;
        gnt       = REQ_D;
      end
      (req_i & req_d): begin
        gnt_valid = 1'b1;
        gnt       = (last_grant == REQ_D) ? REQ_I : REQ_D;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one line-wide memory bus between icache and dcache.
// Grant held per transaction; D stores pulse an icache invalidate.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int OFFSET_LENGTH  = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int LINE_WIDTH    =
    line_width(DATA_WIDTH, OFFSET_LENGTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_command_valid,
  input  logic                  i_command_store,
  input  logic                  i_command_rready,
  input  logic [ADDR_WIDTH-1:0] i_command_addr,
  input  logic [LINE_WIDTH-1:0] i_data_to_bus,
  output logic [LINE_WIDTH-1:0] i_data_from_bus,
  output logic                  i_bus_valid,
  output logic                  i_bus_ready,
  output logic                  i_invalidate,
  output logic [ADDR_WIDTH-1:0] i_invalidate_addr,
  input  logic                  d_command_valid,
  input  logic                  d_command_store,
  input  logic                  d_command_rready,
  input  logic [ADDR_WIDTH-1:0] d_command_addr,
  input  logic [LINE_WIDTH-1:0] d_data_to_bus,
  output logic [LINE_WIDTH-1:0] d_data_from_bus,
  output logic                  d_bus_valid,
  output logic                  d_bus_ready,
  output logic                  m_command_valid,
  output logic                  m_command_store,
  output logic                  m_command_rready,
  output logic [ADDR_WIDTH-1:0] m_command_addr,
  output logic [LINE_WIDTH-1:0] m_data_to_bus,
  input  logic [LINE_WIDTH-1:0] m_data_from_bus,
  input  logic                  m_bus_valid,
  input  logic                  m_bus_ready,
  output logic                  bus_error,
  output logic                  owner
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  arb_state_t            state_q, state_d;
  req_id_t               last_q, last_d;
  req_id_t               owner_q, owner_d;
  logic                  store_q, store_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  inv_q, inv_d;
  logic [ADDR_WIDTH-1:0] inv_addr_q, inv_addr_d;

  logic    gnt_valid;
  req_id_t gnt;
  logic    done;
  logic    unused_rready;

  assign unused_rready = i_command_rready ^ d_command_rready;

  rr_arbiter2 u_rr (
    .req_i      (i_command_valid),
    .req_d      (d_command_valid),
    .last_grant (last_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    store_d    = store_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    inv_d      = 1'b0;
    inv_addr_d = inv_addr_q;
    done       = 1'b0;
    i_bus_valid      = 1'b0;
    i_bus_ready      = 1'b0;
    d_bus_valid      = 1'b0;
    d_bus_ready      = 1'b0;
    m_command_valid  = 1'b0;
    m_command_store  = 1'b0;
    m_command_rready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = BUSY;
          owner_d = gnt;
          cnt_d   = '0;
          if (gnt == REQ_D) begin
            addr_d  = d_command_addr;
            store_d = d_command_store;
            wdata_d = d_data_to_bus;
          end else begin
            addr_d  = i_command_addr;
            store_d = i_command_store;
            wdata_d = i_data_to_bus;
          end
        end
      end
      BUSY: begin
        m_command_valid  = 1'b1;
        m_command_store  = store_q;
        m_command_rready = ~store_q;
        done = store_q ? m_bus_ready : m_bus_valid;
        // Saturating timeout; the transaction keeps waiting.
        if (TIMEOUT_CYCLES != 0 && cnt_q != TMAX) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TMAX) err_d = 1'b1;
        end
        if (done) begin
          state_d = IDLE;
          last_d  = owner_q;
          if (owner_q == REQ_D) begin
            d_bus_valid = ~store_q;
            d_bus_ready = store_q;
            if (store_q) begin
              inv_d      = 1'b1;
              inv_addr_d = addr_q;
            end
          end else begin
            i_bus_valid = ~store_q;
            i_bus_ready = store_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_q     <= REQ_D;
      owner_q    <= REQ_I;
      store_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      inv_q      <= 1'b0;
      inv_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      store_q    <= store_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      inv_q      <= inv_d;
      inv_addr_q <= inv_addr_d;
    end
  end

  assign i_data_from_bus   = m_data_from_bus;
  assign d_data_from_bus   = m_data_from_bus;
  assign m_command_addr    = addr_q;
  assign m_data_to_bus     = wdata_q;
  assign i_invalidate      = inv_q;
  assign i_invalidate_addr = inv_addr_q;
  assign bus_error         = err_q;
  assign owner             = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-level model
// compared every cycle plus hand-computed literal checks.
module tb_mem_bus_arbiter;

  localparam int AW = 64;
  localparam int DW = 16;
  localparam int OL = 2;
  localparam int LW = 64;
  localparam int TO = 8;

  logic          clk;
  logic          reset_n;
  logic          i_cv, i_cs, i_cr;
  logic [AW-1:0] i_ca;
  logic [LW-1:0] i_dtb;
  logic [LW-1:0] i_dfb;
  logic          i_bv, i_br, i_inv;
  logic [AW-1:0] i_inv_a;
  logic          d_cv, d_cs, d_cr;
  logic [AW-1:0] d_ca;
  logic [LW-1:0] d_dtb;
  logic [LW-1:0] d_dfb;
  logic          d_bv, d_br;
  logic          m_cv, m_cs, m_cr;
  logic [AW-1:0] m_ca;
  logic [LW-1:0] m_dtb;
  logic [LW-1:0] m_dfb;
  logic          m_bv, m_br;
  logic          berr, own;

  int n_chk = 0;
  int n_err = 0;

  mem_bus_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .OFFSET_LENGTH  (OL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_command_valid   (i_cv),
    .i_command_store   (i_cs),
    .i_command_rready  (i_cr),
    .i_command_addr    (i_ca),
    .i_data_to_bus     (i_dtb),
    .i_data_from_bus   (i_dfb),
    .i_bus_valid       (i_bv),
    .i_bus_ready       (i_br),
    .i_invalidate      (i_inv),
    .i_invalidate_addr (i_inv_a),
    .d_command_valid   (d_cv),
    .d_command_store   (d_cs),
    .d_command_rready  (d_cr),
    .d_command_addr    (d_ca),
    .d_data_to_bus     (d_dtb),
    .d_data_from_bus   (d_dfb),
    .d_bus_valid       (d_bv),
    .d_bus_ready       (d_br),
    .m_command_valid   (m_cv),
    .m_command_store   (m_cs),
    .m_command_rready  (m_cr),
    .m_command_addr    (m_ca),
    .m_data_to_bus     (m_dtb),
    .m_data_from_bus   (m_dfb),
    .m_bus_valid       (m_bv),
    .m_bus_ready       (m_br),
    .bus_error         (berr),
    .owner             (own)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               name, got, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding bus transfer at a time.
  bit          mb, mo, ms, last, inv, err;
  logic [63:0] ma, mw, inv_addr;
  int          cyc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mb = 0; mo = 0; ms = 0; last = 1;
      inv = 0; err = 0; cyc = 0;
      ma = '0; mw = '0; inv_addr = '0;
    end else begin
      inv = 0;
      if (!mb) begin
        if (i_cv || d_cv) begin
          if (i_cv && d_cv) mo = ~last;
          else mo = d_cv;
          mb  = 1;
          cyc = 0;
          ma  = mo ? d_ca : i_ca;
          ms  = mo ? d_cs : i_cs;
          mw  = mo ? d_dtb : i_dtb;
        end
      end else begin
        cyc++;
        if (TO != 0 && cyc >= TO) err = 1;
        if (ms ? m_br : m_bv) begin
          mb   = 0;
          last = mo;
          if (mo && ms) begin
            inv      = 1;
            inv_addr = ma;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_valid", m_cv, mb);
      chk("m_store", m_cs, mb & ms);
      chk("m_rready", m_cr, mb & ~ms);
      chk("i_bv", i_bv, mb & ~ms & ~mo & m_bv);
      chk("d_bv", d_bv, mb & ~ms & mo & m_bv);
      chk("i_br", i_br, mb & ms & ~mo & m_br);
      chk("d_br", d_br, mb & ms & mo & m_br);
      chk("i_inv", i_inv, inv);
      chk("i_inv_addr", i_inv_a, inv_addr);
      chk("bus_error", berr, err);
      if (mb) begin
        chk("m_addr", m_ca, ma);
        chk("m_wdata", m_dtb, mw);
        chk("owner", own, mo);
      end
      if (i_bv) chk("i_rdata", i_dfb, m_dfb);
      if (d_bv) chk("d_rdata", d_dfb, m_dfb);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_cv = 0; i_cs = 0; i_ca = '0; i_dtb = '0;
    d_cv = 0; d_cs = 0; d_ca = '0; d_dtb = '0;
    m_bv = 0; m_br = 0; m_dfb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_cv, 1'b0);
    chk("rst_m_rready", m_cr, 1'b0);
    chk("rst_owner", own, 1'b0);
    chk("rst_err", berr, 1'b0);
    chk("rst_inv", i_inv, 1'b0);
    chk("rst_i_bv", i_bv, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    i_cr = 1'b1;
    d_cr = 1'b1;
    do_reset();

    // Single I read.
    i_cv = 1; i_cs = 0; i_ca = 64'h1000;
    at_neg();
    chk("t1_latency", m_cv, 1'b0);
    step();
    i_cv = 0;
    at_neg();
    chk("t1_m_valid", m_cv, 1'b1);
    chk("t1_m_addr", m_ca, 64'h1000);
    chk("t1_rready", m_cr, 1'b1);
    step();
    m_bv = 1; m_dfb = 64'hABAB_ABAB_ABAB_ABAB;
    at_neg();
    chk("t1_i_bv", i_bv, 1'b1);
    chk("t1_i_data", i_dfb, 64'hABAB_ABAB_ABAB_ABAB);
    chk("t1_d_bv", d_bv, 1'b0);
    step();
    m_bv = 0;
    at_neg();
    chk("t1_idle", m_cv, 1'b0);

    // Alternation with both requesting from reset.
    do_reset();
    i_cv = 1; i_ca = 64'h100;
    d_cv = 1; d_ca = 64'h200;
    for (int k = 0; k < 4; k++) begin
      step();
      m_bv = 1; m_dfb = 64'(k + 1);
      at_neg();
      chk("t2_owner", own, 64'(k % 2));
      chk("t2_addr", m_ca,
          (k % 2 == 1) ? 64'h200 : 64'h100);
      chk("t2_resp", (k % 2 == 1) ? d_bv : i_bv, 1'b1);
      step();
      m_bv = 0;
    end
    i_cv = 0; d_cv = 0;

    // D store invalidates; I store does not.
    d_cv = 1; d_cs = 1; d_ca = 64'h2040;
    d_dtb = 64'h1122_3344_5566_7788;
    step();
    d_cv = 0; m_br = 1;
    at_neg();
    chk("t3_d_br", d_br, 1'b1);
    chk("t3_i_br", i_br, 1'b0);
    chk("t3_store", m_cs, 1'b1);
    chk("t3_wdata", m_dtb, 64'h1122_3344_5566_7788);
    step();
    m_br = 0;
    at_neg();
    chk("t3_inv", i_inv, 1'b1);
    chk("t3_inv_addr", i_inv_a, 64'h2040);
    step();
    at_neg();
    chk("t3_inv_off", i_inv, 1'b0);
    chk("t3_inv_hold", i_inv_a, 64'h2040);
    i_cv = 1; i_cs = 1; i_ca = 64'h3000;
    i_dtb = 64'h5555_AAAA_5555_AAAA;
    step();
    i_cv = 0; m_br = 1;
    at_neg();
    chk("t3_i_br", i_br, 1'b1);
    step();
    m_br = 0;
    at_neg();
    chk("t3_no_inv", i_inv, 1'b0);
    step();

    // I drops valid mid-read while D waits.
    i_cv = 1; i_cs = 0; i_ca = 64'h4000;
    step();
    i_cv = 0;
    d_cv = 1; d_cs = 0; d_ca = 64'h5000;
    m_br = 1;
    for (int j = 0; j < 3; j++) begin
      at_neg();
      chk("t4_addr", m_ca, 64'h4000);
      chk("t4_d_bv", d_bv, 1'b0);
      step();
    end
    m_br = 0; m_bv = 1; m_dfb = 64'h0F0F_0F0F_0F0F_0F0F;
    at_neg();
    chk("t4_i_bv", i_bv, 1'b1);
    chk("t4_d_bv_end", d_bv, 1'b0);
    step();
    m_bv = 0;
    at_neg();
    chk("t4_gap", m_cv, 1'b0);
    step();
    d_cv = 0; m_bv = 1;
    at_neg();
    chk("t4_owner", own, 1'b1);
    chk("t4_d_addr", m_ca, 64'h5000);
    chk("t4_d_bv_now", d_bv, 1'b1);
    step();
    m_bv = 0;

    // Timeout, then asynchronous reset mid-transfer.
    i_cv = 1; i_cs = 0; i_ca = 64'h6000;
    step();
    i_cv = 0;
    for (int n = 1; n <= 12; n++) begin
      at_neg();
      chk("t5_err", berr, (n >= 9) ? 1'b1 : 1'b0);
      step();
    end
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", m_cv, 1'b0);
    chk("t5_rst_err", berr, 1'b0);
    chk("t5_rst_owner", own, 1'b0);
    chk("t5_rst_rready", m_cr, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    step();
    at_neg();
    chk("t5_idle", m_cv, 1'b0);
    chk("t5_err_clr", berr, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
